// File: rtl/ram_b_arbiter_pkg.sv
// Shared types and constants for the RAM port-B arbiter.
package ram_b_arbiter_pkg;

  localparam int unsigned RAM_B_WORD_W     = 32;
  localparam int unsigned RAM_B_STRB_W     = 4;
  // Widest word address the command register can carry; ADDR_WIDTH must not exceed it.
  localparam int unsigned RAM_B_ADDR_MAX_W = 16;

  typedef enum logic {
    OWNER_P0 = 1'b0,
    OWNER_P1 = 1'b1
  } ram_b_owner_e;

  typedef struct packed {
    logic [RAM_B_ADDR_MAX_W-1:0] addr;
    logic [RAM_B_WORD_W-1:0]     wdata;
    logic [RAM_B_STRB_W-1:0]     wstrb;
    ram_b_owner_e                owner;
    logic                        valid;
  } ram_b_cmd_t;

  // Byte write enable presented to the RAM: an idle command register never writes.
  function automatic logic [RAM_B_STRB_W-1:0] ram_b_wea(input ram_b_cmd_t cmd);
    return cmd.valid ? cmd.wstrb : '0;
  endfunction

endpackage

// File: rtl/ram_b_arb_grant.sv
// Grant selection for the two RAM port-B requesters.
// Default: fixed priority to port 0 with a starvation guard for port 1.
// Build macro RAM_B_ARB_RR_EN: 1-bit round-robin pointer replaces the starvation guard.
module ram_b_arb_grant
  import ram_b_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clka,
  input  logic rst_n,
  input  logic p0_valid,
  input  logic p1_valid,
  output logic p0_gnt,
  output logic p1_gnt
);

`ifdef RAM_B_ARB_RR_EN

  ram_b_owner_e rr_ptr;

  // Preferred port wins a conflict; a lone requester always wins.
  always_comb begin
    p1_gnt = rst_n && p1_valid && (!p0_valid || (rr_ptr == OWNER_P1));
    p0_gnt = rst_n && p0_valid && !p1_gnt;
  end

  // Pointer moves to the port that did not win.
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= OWNER_P0;
    end else if (p0_gnt) begin
      rr_ptr <= OWNER_P1;
    end else if (p1_gnt) begin
      rr_ptr <= OWNER_P0;
    end
  end

`else

  localparam int unsigned CNT_W = 4;

  logic [CNT_W-1:0] starve_cnt;
  logic             starve_hit;

  // Port 0 wins unless port 1 has waited through STARVE_LIMIT port-0 grants.
  always_comb begin
    starve_hit = (starve_cnt == CNT_W'(STARVE_LIMIT));
    p1_gnt     = rst_n && p1_valid && (!p0_valid || starve_hit);
    p0_gnt     = rst_n && p0_valid && !p1_gnt;
  end

  // Count port-0 wins while port 1 waits; saturate at the limit.
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!p1_valid || p1_gnt) begin
      starve_cnt <= '0;
    end else if (p0_gnt && !starve_hit) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

`endif

endmodule

// File: rtl/ram_b_arbiter.sv
// Two-port arbiter in front of a single-port, byte-enabled, read-first word RAM.
// Accepted commands are registered onto the RAM port; responses return two cycles
// after the handshake to the owning port. Build macro RAM_B_ARB_RR_EN selects
// round-robin arbitration instead of fixed priority with starvation guard.
module ram_b_arbiter
  import ram_b_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 6,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                    clka,
  input  logic                    rst_n,

  input  logic                    p0_req_valid,
  output logic                    p0_req_ready,
  input  logic [ADDR_WIDTH-1:0]   p0_addr,
  input  logic [RAM_B_WORD_W-1:0] p0_wdata,
  input  logic [RAM_B_STRB_W-1:0] p0_wstrb,
  output logic                    p0_rsp_valid,
  output logic [RAM_B_WORD_W-1:0] p0_rsp_rdata,

  input  logic                    p1_req_valid,
  output logic                    p1_req_ready,
  input  logic [ADDR_WIDTH-1:0]   p1_addr,
  input  logic [RAM_B_WORD_W-1:0] p1_wdata,
  input  logic [RAM_B_STRB_W-1:0] p1_wstrb,
  output logic                    p1_rsp_valid,
  output logic [RAM_B_WORD_W-1:0] p1_rsp_rdata,

  output logic [ADDR_WIDTH-1:0]   ram_addra,
  output logic [RAM_B_WORD_W-1:0] ram_dina,
  output logic [RAM_B_STRB_W-1:0] ram_wea,
  input  logic [RAM_B_WORD_W-1:0] ram_douta
);

  logic         p0_gnt;
  logic         p1_gnt;
  ram_b_cmd_t   cmd_d;
  ram_b_cmd_t   cmd_q;
  logic         rsp_valid_q;
  ram_b_owner_e rsp_owner_q;

  ram_b_arb_grant #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_grant (
    .clka     (clka),
    .rst_n    (rst_n),
    .p0_valid (p0_req_valid),
    .p1_valid (p1_req_valid),
    .p0_gnt   (p0_gnt),
    .p1_gnt   (p1_gnt)
  );

  assign p0_req_ready = p0_gnt;
  assign p1_req_ready = p1_gnt;

  // Next command: load the winner; otherwise keep addr/data so the RAM pins stay quiet.
  always_comb begin
    cmd_d       = cmd_q;
    cmd_d.valid = p0_gnt | p1_gnt;
    if (p1_gnt) begin
      cmd_d.addr  = RAM_B_ADDR_MAX_W'(p1_addr);
      cmd_d.wdata = p1_wdata;
      cmd_d.wstrb = p1_wstrb;
      cmd_d.owner = OWNER_P1;
    end else if (p0_gnt) begin
      cmd_d.addr  = RAM_B_ADDR_MAX_W'(p0_addr);
      cmd_d.wdata = p0_wdata;
      cmd_d.wstrb = p0_wstrb;
      cmd_d.owner = OWNER_P0;
    end
  end

  // Stage 1 drives the RAM; stage 2 tracks the RAM read latency for response routing.
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_owner_q <= OWNER_P0;
    end else begin
      cmd_q       <= cmd_d;
      rsp_valid_q <= cmd_q.valid;
      rsp_owner_q <= cmd_q.owner;
    end
  end

  // RAM port and response routing; rdata goes to both ports, only the owner sees valid.
  always_comb begin
    ram_addra    = cmd_q.addr[ADDR_WIDTH-1:0];
    ram_dina     = cmd_q.wdata;
    ram_wea      = ram_b_wea(cmd_q);
    p0_rsp_valid = rsp_valid_q && (rsp_owner_q == OWNER_P0);
    p1_rsp_valid = rsp_valid_q && (rsp_owner_q == OWNER_P1);
    p0_rsp_rdata = ram_douta;
    p1_rsp_rdata = ram_douta;
  end

  if (ADDR_WIDTH < RAM_B_ADDR_MAX_W) begin : g_addr_pad
    // Upper command address bits are always zero for this instance.
    logic unused_addr_hi;
    assign unused_addr_hi = ^cmd_q.addr[RAM_B_ADDR_MAX_W-1:ADDR_WIDTH];
  end

endmodule

// File: tb/tb_ram_b_arbiter.sv
// Scoreboard bench for ram_b_arbiter with a behavioural read-first RAM.
// Grant-order expectations follow RAM_B_ARB_RR_EN when it is defined.
module tb_ram_b_arbiter;

  localparam int unsigned AW = 6;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
  } req_t;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic          clka = 1'b0;
  logic          rst_n;
  logic          p0_req_valid, p1_req_valid;
  logic          p0_req_ready, p1_req_ready;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [31:0]   p0_wdata, p1_wdata;
  logic [3:0]    p0_wstrb, p1_wstrb;
  logic          p0_rsp_valid, p1_rsp_valid;
  logic [31:0]   p0_rsp_rdata, p1_rsp_rdata;
  logic [AW-1:0] ram_addra;
  logic [31:0]   ram_dina;
  logic [3:0]    ram_wea;
  logic [31:0]   ram_douta;

  logic          load_en;
  logic [31:0]   ram_mem [64];
  logic [31:0]   ref_mem [64];
  int            cyc = 0;
  int            n_checks = 0;
  int            n_errors = 0;

  req_t pend0[$], pend1[$];
  exp_t exp0[$], exp1[$];
  int   glog[$];

  ram_b_arbiter #(
    .ADDR_WIDTH   (AW),
    .STARVE_LIMIT (4)
  ) dut (
    .clka         (clka),
    .rst_n        (rst_n),
    .p0_req_valid (p0_req_valid),
    .p0_req_ready (p0_req_ready),
    .p0_addr      (p0_addr),
    .p0_wdata     (p0_wdata),
    .p0_wstrb     (p0_wstrb),
    .p0_rsp_valid (p0_rsp_valid),
    .p0_rsp_rdata (p0_rsp_rdata),
    .p1_req_valid (p1_req_valid),
    .p1_req_ready (p1_req_ready),
    .p1_addr      (p1_addr),
    .p1_wdata     (p1_wdata),
    .p1_wstrb     (p1_wstrb),
    .p1_rsp_valid (p1_rsp_valid),
    .p1_rsp_rdata (p1_rsp_rdata),
    .ram_addra    (ram_addra),
    .ram_dina     (ram_dina),
    .ram_wea      (ram_wea),
    .ram_douta    (ram_douta)
  );

  always #5 clka = ~clka;

  always @(posedge clka) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input int i);
    if (i == 3) return 32'h11223344;
    return {8'hA5, 8'(i), 8'(i * 7), 8'hC3};
  endfunction

  // Read-first RAM with registered output and byte enables.
  always @(posedge clka) begin
    if (load_en) begin
      for (int i = 0; i < 64; i++) ram_mem[i] <= init_word(i);
    end else begin
      ram_douta <= ram_mem[ram_addra];
      for (int b = 0; b < 4; b++)
        if (ram_wea[b]) ram_mem[ram_addra][8*b +: 8] <= ram_dina[8*b +: 8];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: compute read-first data and apply the write at acceptance time.
  task automatic accept(input int port, input req_t r);
    exp_t e;
    e.data = ref_mem[r.addr];
    e.cyc  = cyc;
    for (int b = 0; b < 4; b++)
      if (r.wstrb[b]) ref_mem[r.addr][8*b +: 8] = r.wdata[8*b +: 8];
    if (port == 0) exp0.push_back(e);
    else exp1.push_back(e);
  endtask

  task automatic check_rsp();
    exp_t e;
    check("rsp_both", 32'(p0_rsp_valid & p1_rsp_valid), 32'd0);
    if (p0_rsp_valid) begin
      if (exp0.size() == 0) check("p0_rsp_unexpected", 32'd1, 32'd0);
      else begin
        e = exp0.pop_front();
        check("p0_rdata", p0_rsp_rdata, e.data);
        check("p0_latency", 32'(cyc - e.cyc), 32'd2);
      end
    end
    if (p1_rsp_valid) begin
      if (exp1.size() == 0) check("p1_rsp_unexpected", 32'd1, 32'd0);
      else begin
        e = exp1.pop_front();
        check("p1_rdata", p1_rsp_rdata, e.data);
        check("p1_latency", 32'(cyc - e.cyc), 32'd2);
      end
    end
  endtask

  // One clock: drive heads of the pending queues, sample at negedge, then advance.
  task automatic step();
    p0_req_valid = (pend0.size() > 0);
    p1_req_valid = (pend1.size() > 0);
    if (pend0.size() > 0) begin
      p0_addr = pend0[0].addr; p0_wdata = pend0[0].wdata; p0_wstrb = pend0[0].wstrb;
    end
    if (pend1.size() > 0) begin
      p1_addr = pend1[0].addr; p1_wdata = pend1[0].wdata; p1_wstrb = pend1[0].wstrb;
    end
    @(negedge clka);
    check_rsp();
    check("ready_onehot", 32'(p0_req_ready & p1_req_ready), 32'd0);
    check("p0_ready_no_valid", 32'(p0_req_ready & ~p0_req_valid), 32'd0);
    check("p1_ready_no_valid", 32'(p1_req_ready & ~p1_req_valid), 32'd0);
    if (p0_req_ready) begin
      accept(0, pend0.pop_front());
      glog.push_back(0);
    end else if (p1_req_ready) begin
      accept(1, pend1.pop_front());
      glog.push_back(1);
    end else begin
      glog.push_back(-1);
    end
    @(posedge clka);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((pend0.size() + pend1.size() + exp0.size() + exp1.size() > 0) && n < 80) begin
      step();
      n++;
    end
    check("drain_left", 32'(pend0.size() + pend1.size() + exp0.size() + exp1.size()), 32'd0);
    repeat (3) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    p0_req_valid = 1'b0;
    p1_req_valid = 1'b0;
    pend0.delete(); pend1.delete(); exp0.delete(); exp1.delete();
    @(posedge clka);
    @(posedge clka);
    #1;
    rst_n = 1'b1;
  endtask

  // Port-0 request granted, then reset asserted before the RAM samples it.
  task automatic mid_reset(input logic [AW-1:0] a, input logic [31:0] wd, input logic [3:0] st);
    logic [31:0] saved;
    req_t r;
    saved = ref_mem[a];
    r.addr = a; r.wdata = wd; r.wstrb = st;
    pend0.push_back(r);
    step();
    check("mid_rst_grant", 32'(glog[glog.size()-1]), 32'd0);
    rst_n = 1'b0;
    p0_req_valid = 1'b0;
    p1_req_valid = 1'b0;
    exp0.delete(); exp1.delete();
    ref_mem[a] = saved;
    @(negedge clka);
    check("mid_rst_rsp", 32'(p0_rsp_valid), 32'd0);
    check("mid_rst_wea", 32'(ram_wea), 32'd0);
    @(posedge clka);
    #1;
    rst_n = 1'b1;
    repeat (3) step();
  endtask

  initial begin
    req_t r;
    int   e;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    p0_addr = '0; p0_wdata = '0; p0_wstrb = '0;
    p1_addr = '0; p1_wdata = '0; p1_wstrb = '0;
    p0_req_valid = 1'b1;
    p1_req_valid = 1'b1;
    rst_n   = 1'b0;
    load_en = 1'b1;
    @(posedge clka);
    #1;
    load_en = 1'b0;

    // Held in reset with requests pending: nothing may be granted or driven.
    @(negedge clka);
    check("rst_p0_ready", 32'(p0_req_ready), 32'd0);
    check("rst_p1_ready", 32'(p1_req_ready), 32'd0);
    check("rst_p0_rsp", 32'(p0_rsp_valid), 32'd0);
    check("rst_p1_rsp", 32'(p1_rsp_valid), 32'd0);
    check("rst_wea", 32'(ram_wea), 32'd0);
    check("rst_addra", 32'(ram_addra), 32'd0);
    check("rst_dina", ram_dina, 32'd0);
    @(posedge clka);
    #1;
    p0_req_valid = 1'b0;
    p1_req_valid = 1'b0;
    rst_n = 1'b1;

    // Idle after reset release.
    for (int i = 0; i < 5; i++) begin
      @(negedge clka);
      check("idle_ready", 32'({p0_req_ready, p1_req_ready}), 32'd0);
      check("idle_rsp", 32'({p0_rsp_valid, p1_rsp_valid}), 32'd0);
      check("idle_wea", 32'(ram_wea), 32'd0);
      @(posedge clka);
      #1;
    end

    // Partial write then read-back of the same word on the next cycle.
    r.addr = 6'd3; r.wdata = 32'hDEADBEEF; r.wstrb = 4'b0011; pend0.push_back(r);
    r.addr = 6'd3; r.wdata = 32'h0;        r.wstrb = 4'b0000; pend0.push_back(r);
    drain();

    // Both ports requesting continuously.
    do_reset();
    glog.delete();
    for (int i = 0; i < 10; i++) begin
      r.addr = 6'(8 + i);  r.wdata = $urandom; r.wstrb = (i % 2 == 1) ? 4'(i) : 4'b0000;
      pend0.push_back(r);
      r.addr = 6'(20 + i); r.wdata = $urandom; r.wstrb = (i % 3 == 0) ? 4'b1111 : 4'b0000;
      pend1.push_back(r);
    end
    for (int i = 0; i < 10; i++) step();
    for (int i = 0; i < 10; i++) begin
`ifdef RAM_B_ARB_RR_EN
      e = i % 2;
`else
      e = (i % 5 == 4) ? 1 : 0;
`endif
      check("grant_seq", 32'(glog[i]), 32'(e));
    end
    drain();

    // Lone port-1 burst of reads: granted every cycle, data in address order.
    glog.delete();
    for (int i = 0; i < 8; i++) begin
      r.addr = 6'(i); r.wdata = '0; r.wstrb = '0;
      pend1.push_back(r);
    end
    drain();
    for (int i = 0; i < 8; i++) check("p1_burst_grant", 32'(glog[i]), 32'd1);

    // Reset arriving while a read and then a write are in flight.
    mid_reset(6'd5, 32'h0, 4'b0000);
    mid_reset(6'd9, 32'hCAFEF00D, 4'b1111);
    r.addr = 6'd9; r.wdata = '0; r.wstrb = '0; pend0.push_back(r);
    r.addr = 6'd5; r.wdata = '0; r.wstrb = '0; pend0.push_back(r);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ram_b_arbiter.md
Name: ram_b_arbiter

Overview:
- Shares one single-port, byte-enabled word RAM (1-cycle registered read) between two requesters: port 0 is the CPU data side, port 1 is a DMA/display fetch side.
- Accepts valid/ready requests and registers the winning command onto the RAM port.
- Returns read data or a write acknowledge to the owning requester with fixed latency.
- Sits between the core/DMA interconnect and the RAM instance.

Parameters:
- ADDR_WIDTH, 6, word-address width; must match the RAM instance.
- STARVE_LIMIT, 4, maximum consecutive port-0 grants while port 1 is waiting (fixed-priority mode only); range 1..15.

Ports:
- clka  in  1  clock, shared with the RAM.
- rst_n  in  1  reset, asynchronous assert, active-low.
- p0_req_valid / p1_req_valid  in  1  request valid.
- p0_req_ready / p1_req_ready  out  1  request accepted this cycle (grant).
- p0_addr / p1_addr  in  ADDR_WIDTH  word address.
- p0_wdata / p1_wdata  in  32  write data.
- p0_wstrb / p1_wstrb  in  4  byte enables; LSB = byte 0; all zero = read.
- p0_rsp_valid / p1_rsp_valid  out  1  response strobe, one cycle.
- p0_rsp_rdata / p1_rsp_rdata  out  32  RAM word; meaningful when rsp_valid.
- ram_addra  out  ADDR_WIDTH  to RAM address.
- ram_dina  out  32  to RAM write data.
- ram_wea  out  4  to RAM byte write enable.
- ram_douta  in  32  from RAM read data.

Behaviour:
- Clocking and reset: one clock, clka. Reset is asynchronous and active-low (rst_n). While rst_n=0:
  - ready=0, rsp_valid=0, ram_wea=0, ram_addra=0, ram_dina=0, stage valids=0, starvation counter=0, RR pointer=port 0.
- Grant (combinational, cycle T):
  - At most one port gets ready=1, and only if its req_valid=1.
  - The arbiter accepts every cycle; there is no internal stall.
- Fixed-priority policy:
  - Port 0 wins unless port 1 is waiting and starve_cnt==STARVE_LIMIT. In that case port 1 wins and starve_cnt is cleared.
  - starve_cnt increments on each port-0 grant while p1_req_valid=1, saturating at STARVE_LIMIT.
  - starve_cnt clears on any port-1 grant or on any cycle with p1_req_valid=0.
- Stage 1 (edge ending T): the accepted command is latched into a command register: addr, wdata, wstrb, owner, valid.
  - During T+1, ram_addra, ram_dina and ram_wea come from this register.
  - ram_wea is forced to 0 when the register is not valid.
  - ram_addra and ram_dina hold their last values when idle.
- Stage 2 (edge ending T+1): the RAM samples the command. owner and valid shift into a response register.
- Response (cycle T+2): the owner's rsp_valid=1 and rsp_rdata=ram_douta; the other port's rsp_valid=0.
  - Total latency from handshake edge to rsp_valid is 2 cycles.
  - Throughput is 1 request per cycle.
- Writes also respond. rsp_rdata then holds the pre-write word (RAM is read-first).
- A read issued the cycle after a write to the same address returns the new data. No hazard logic is required.
- rsp_rdata of the non-owner port is don't-care.
- Responses cannot be back-pressured; requesters must sink them.
- Requests are in order per port; responses return in acceptance order.
- Reset mid-operation: in-flight commands are discarded, with no rsp_valid and no RAM write after the assert edge. A write already sampled by the RAM before reset persists.
- Simultaneous valid on both ports: exactly one grant per the active policy. The loser holds its request (valid/addr stable until ready).

Optional Feature:
- RAM_B_ARB_RR_EN defined: round-robin replaces fixed priority + starvation.
  - A 1-bit pointer names the preferred port. On any grant it moves to the other port.
  - A lone requester is always granted.
  - STARVE_LIMIT and starve_cnt are unused, and starve_cnt is not instantiated.
- RAM_B_ARB_RR_EN not defined: fixed priority with starvation guard, as in Behaviour.

Decomposition:
- Shared package holds:
  - RAM_B_WORD_W=32 and RAM_B_STRB_W=4;
  - an owner encoding, OWNER_P0=0 and OWNER_P1=1;
  - a command struct typedef {addr, wdata, wstrb, owner, valid}.
- One sub-module, ram_b_arb_grant: purely combinational grant selection plus the starvation/RR state register. It is instantiated once.
- Pipeline registers and response routing stay in ram_b_arbiter.

Test Plan:
- Reset-release with both valid=0 -> all ready/rsp_valid=0, ram_wea=0 for 5 cycles.
- p0 write addr 3, wdata 0xDEADBEEF, wstrb 4'b0011; next cycle p0 read addr 3 (RAM preloaded with 0x11223344) -> RAM word becomes 0x1122BEEF. Write rsp at T+2 has rdata 0x11223344; read rsp at T+3 has rdata 0x1122BEEF.
- Both ports valid continuously, fixed priority, STARVE_LIMIT=4 -> grant sequence P0,P0,P0,P0,P1 repeating. Every rsp_valid is routed to the correct port 2 cycles after its grant.
- Same stimulus with RAM_B_ARB_RR_EN -> grants alternate P0,P1,P0,P1. A lone p1 requester is granted every cycle.
- Back-to-back p1 reads addr 0..7 -> 8 consecutive p1_rsp_valid cycles starting 2 cycles after the first grant, with data in address order.
- rst_n pulsed low the cycle after a p0 read grant -> no p0_rsp_valid, ram_wea=0. After release, the next request completes normally.
